// File: rtl/round_ctrl.sv
// Match/round sequencer: runs intro, fight, pause and post-round phases, drives the
// round Timer, judges each round by KO or time-out and tallies wins until a match winner emerges.
module round_ctrl #(
  parameter int WIN_ROUNDS = 2,
  parameter int INTRO_CYC  = 200,
  parameter int END_CYC    = 300,
  parameter int HP_W       = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            pause_btn_i,
  input  logic [HP_W-1:0] p1_hp_i,
  input  logic [HP_W-1:0] p2_hp_i,
  input  logic [6:0]      remain_t_i,
  input  logic            timeout_i,
  output logic            timer_reset_o,
  output logic            timer_keep_o,
  output logic            fight_en_o,
  output logic [2:0]      round_num_o,
  output logic [1:0]      p1_wins_o,
  output logic [1:0]      p2_wins_o,
  output logic [1:0]      round_winner_o,
  output logic            match_over_o,
  output logic [1:0]      match_winner_o,
  output logic [6:0]      time_disp_o
);

  localparam int MAX_CYC = (INTRO_CYC > END_CYC) ? INTRO_CYC : END_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INTRO_LAST = CNT_W'(INTRO_CYC - 1);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_CYC - 1);
  localparam logic [1:0]       WIN_TGT    = 2'(WIN_ROUNDS);
  localparam logic [2:0]       LAST_ROUND = 3'd7;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INTRO,
    S_FIGHT,
    S_PAUSE,
    S_END,
    S_MATCH_END
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       round_q, round_d;
  logic [1:0]       p1w_q, p1w_d;
  logic [1:0]       p2w_q, p2w_d;
  logic [1:0]       rwin_q, rwin_d;
  logic [1:0]       mwin_q, mwin_d;
  logic             timer_reset_q, keep_q, fight_q, over_q;
  logic [6:0]       time_q;

  logic             p1_out, p2_out;
  logic [1:0]       result;

  assign p1_out = (p1_hp_i == '0);
  assign p2_out = (p2_hp_i == '0);

  // Round verdict for this cycle; a KO outranks a simultaneous time-out.
  always_comb begin
    result = W_NONE;
    if (p1_out || p2_out) begin
      if (p1_out && p2_out) result = W_DRAW;
      else if (p1_out)      result = W_P2;
      else                  result = W_P1;
    end else if (timeout_i) begin
      if (p1_hp_i > p2_hp_i)      result = W_P1;
      else if (p2_hp_i > p1_hp_i) result = W_P2;
      else                        result = W_DRAW;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    round_d = round_q;
    p1w_d   = p1w_q;
    p2w_d   = p2w_q;
    rwin_d  = rwin_q;
    mwin_d  = mwin_q;

    case (state_q)
      S_IDLE, S_MATCH_END: begin
        if (start_i) begin
          state_d = S_INTRO;
          round_d = 3'd1;
          p1w_d   = '0;
          p2w_d   = '0;
          rwin_d  = W_NONE;
          mwin_d  = W_NONE;
        end
      end

      S_INTRO: begin
        if (cnt_q == INTRO_LAST) state_d = S_FIGHT;
      end

      S_FIGHT: begin
        if (result != W_NONE) begin
          state_d = S_END;
          rwin_d  = result;
          if (result == W_P1 && p1w_q != WIN_TGT) p1w_d = p1w_q + 2'd1;
          if (result == W_P2 && p2w_q != WIN_TGT) p2w_d = p2w_q + 2'd1;
        end else if (pause_btn_i) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (pause_btn_i) state_d = S_FIGHT;
      end

      // Match ends on a decisive tally, or on the draw cap once round 7 is played out.
      S_END: begin
        if (cnt_q == END_LAST) begin
          if (p1w_q == WIN_TGT) begin
            state_d = S_MATCH_END;
            mwin_d  = W_P1;
          end else if (p2w_q == WIN_TGT) begin
            state_d = S_MATCH_END;
            mwin_d  = W_P2;
          end else if (round_q == LAST_ROUND) begin
            state_d = S_MATCH_END;
            mwin_d  = W_DRAW;
          end else begin
            state_d = S_INTRO;
            round_d = round_q + 3'd1;
            rwin_d  = W_NONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      p1w_q   <= '0;
      p2w_q   <= '0;
      rwin_q  <= W_NONE;
      mwin_q  <= W_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      p1w_q   <= p1w_d;
      p2w_q   <= p2w_d;
      rwin_q  <= rwin_d;
      mwin_q  <= mwin_d;
    end
  end

  // Timer controls are decoded from the next state so they change with the state itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_reset_q <= 1'b1;
      keep_q        <= 1'b1;
      fight_q       <= 1'b0;
      over_q        <= 1'b0;
      time_q        <= '0;
    end else begin
      timer_reset_q <= (state_d == S_IDLE) || (state_d == S_INTRO) || (state_d == S_MATCH_END);
      keep_q        <= (state_d != S_FIGHT);
      fight_q       <= (state_d == S_FIGHT);
      over_q        <= (state_d == S_MATCH_END);
      time_q        <= ((state_d == S_FIGHT) || (state_d == S_PAUSE)) ? remain_t_i : 7'd0;
    end
  end

  assign timer_reset_o  = timer_reset_q;
  assign timer_keep_o   = keep_q;
  assign fight_en_o     = fight_q;
  assign round_num_o    = round_q;
  assign p1_wins_o      = p1w_q;
  assign p2_wins_o      = p2w_q;
  assign round_winner_o = rwin_q;
  assign match_over_o   = over_q;
  assign match_winner_o = mwin_q;
  assign time_disp_o    = time_q;

endmodule
